// File: rtl/alu_issue_ctrl.sv
// Sequences one instruction at a time into an external combinational ALU, with an 8-entry register file.
// ALU ops retire 2 edges after acceptance, MV after 1 and MVI on its immediate; instr_ready is low while an op is in LOAD/EXEC.
module alu_issue_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [WIDTH-1:0] instr,
   output logic [2:0]       alu_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   output logic             done,
   output logic             div_err,
   input  logic [2:0]       dbg_sel,
   output logic [WIDTH-1:0] dbg_data
);

   typedef enum logic [1:0] {IDLE, LOAD, EXEC, IMM} state_t;

   localparam logic [2:0] OP_DIV = 3'b100;
   localparam logic [2:0] OP_MVI = 3'b110;
   localparam logic [2:0] OP_MV  = 3'b111;

   state_t           state;
   logic [2:0]       op;
   logic [2:0]       rx;
   logic [2:0]       ry;
   logic             div_zero;
   logic             accept;
   logic [2:0]       instr_op;
   logic [WIDTH-1:0] regs [8];

   assign instr_ready = !reset && (state == IDLE || state == IMM);
   assign accept      = instr_valid && instr_ready;
   assign instr_op    = instr[WIDTH-1 -: 3];
   assign dbg_data    = regs[dbg_sel];

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         op       <= '0;
         rx       <= '0;
         ry       <= '0;
         div_zero <= 1'b0;
         alu_sel  <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         done     <= 1'b0;
         div_err  <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            regs[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  op    <= instr_op;
                  rx    <= instr[WIDTH-4 -: 3];
                  ry    <= instr[WIDTH-7 -: 3];
                  state <= (instr_op == OP_MVI) ? IMM : LOAD;
               end
            end
            LOAD: begin
               if (op == OP_MV) begin
                  regs[rx] <= regs[ry];
                  done     <= 1'b1;
                  state    <= IDLE;
               end else begin
                  // Operands are captured here, so rx==ry sees the pre-writeback value.
                  alu_sel  <= op;
                  alu_a    <= regs[rx];
                  alu_b    <= regs[ry];
                  div_zero <= (op == OP_DIV) && (regs[ry] == '0);
                  if ((op == OP_DIV) && (regs[ry] == '0)) begin
                     div_err <= 1'b1;
                  end
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (!div_zero) begin
                  regs[rx] <= alu_result;
               end
               done  <= 1'b1;
               state <= IDLE;
            end
            IMM: begin
               if (accept) begin
                  regs[rx] <= instr;
                  done     <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: bench-side ALU, event-scheduled reference model, directed and random stimulus.
module tb_alu_issue_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [2:0]  alu_sel;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_result;
   logic        done;
   logic        div_err;
   logic [2:0]  dbg_sel;
   logic [15:0] dbg_data;

   int n_checks = 0;
   int n_fail   = 0;

   alu_issue_ctrl #(.WIDTH(16)) dut (
      .clock      (clock),
      .reset      (reset),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr      (instr),
      .alu_sel    (alu_sel),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .done       (done),
      .div_err    (div_err),
      .dbg_sel    (dbg_sel),
      .dbg_data   (dbg_data)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] prod;
      prod = a * b;
      case (op)
         3'd0:    return a + b;
         3'd1:    return a ^ b;
         3'd2:    return a - b;
         3'd3:    return prod[15:0];
         3'd4:    return (b == 16'd0) ? 16'hFFFF : a / b;
         3'd5:    return 16'($countones(b));
         default: return 16'd0;
      endcase
   endfunction

   always_comb alu_result = alu_fn(alu_sel, alu_a, alu_b);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each accepted instruction schedules its effects at absolute edge numbers.
   int          edge_n = 0;
   bit          m_init = 0;
   logic [15:0] m_r [8];
   logic        m_div_err, m_done, m_ready, m_imm;
   logic [2:0]  m_imm_rx, m_sel;
   logic [15:0] m_a, m_b;
   bit          p_act, p_alu, p_divz, acc;
   int          p_alu_edge, p_wr_edge;
   logic [2:0]  p_op, p_rx, d_op, d_rx, d_ry;
   logic [15:0] p_a, p_b, p_val;

   always @(posedge clock) begin
      edge_n++;
      m_done = 1'b0;
      acc = instr_valid && m_ready;
      if (reset) begin
         m_init = 1;
         for (int i = 0; i < 8; i++) m_r[i] = 16'd0;
         m_div_err = 0; m_ready = 1; m_imm = 0; m_imm_rx = 0;
         m_sel = 0; m_a = 0; m_b = 0; p_act = 0;
      end else if (m_init) begin
         if (p_act && p_alu && edge_n == p_alu_edge) begin
            m_sel = p_op; m_a = p_a; m_b = p_b;
            if (p_divz) m_div_err = 1;
         end
         if (p_act && edge_n == p_wr_edge) begin
            if (!p_divz) m_r[p_rx] = p_val;
            m_done = 1;
            p_act = 0;
         end
         if (acc) begin
            if (m_imm) begin
               m_r[m_imm_rx] = instr;
               m_done = 1;
               m_imm = 0;
            end else begin
               d_op = instr[15:13]; d_rx = instr[12:10]; d_ry = instr[9:7];
               if (d_op == 3'd6) begin
                  m_imm = 1; m_imm_rx = d_rx;
               end else if (d_op == 3'd7) begin
                  p_act = 1; p_alu = 0; p_divz = 0; p_rx = d_rx;
                  p_val = m_r[d_ry]; p_wr_edge = edge_n + 1;
               end else begin
                  p_act = 1; p_alu = 1; p_op = d_op; p_rx = d_rx;
                  p_a = m_r[d_rx]; p_b = m_r[d_ry];
                  p_divz = (d_op == 3'd4) && (p_b == 16'd0);
                  p_val = alu_fn(d_op, p_a, p_b);
                  p_alu_edge = edge_n + 1; p_wr_edge = edge_n + 2;
               end
            end
         end
         m_ready = !p_act;
      end
   end

   always @(negedge clock) begin
      if (m_init) begin
         chk("instr_ready", instr_ready, m_ready && !reset);
         chk("done", done, m_done);
         chk("div_err", div_err, m_div_err);
         chk("alu_sel", alu_sel, m_sel);
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         chk("dbg_data", dbg_data, m_r[dbg_sel]);
      end
   end

   function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry);
      return {op, rx, ry, 7'h2A};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [15:0] w);
      int  n;
      logic r;
      instr_valid = 1'b1;
      instr = w;
      n = 0;
      forever begin
         #1;
         r = instr_ready;
         step();
         if (r) break;
         n++;
         if (n > 50) begin
            chk("accept_timeout", 32'd0, 32'd1);
            break;
         end
      end
      instr_valid = 1'b0;
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      while (!done && cnt < 20) begin
         step();
         cnt++;
      end
   endtask

   task automatic run(input logic [15:0] w);
      int c;
      issue(w);
      wait_done(c);
      chk("run_done", done, 1'b1);
   endtask

   task automatic mvi(input logic [2:0] rx, input logic [15:0] val);
      issue(enc(3'd6, rx, 3'd0));
      issue(val);
   endtask

   task automatic expect_reg(input logic [2:0] idx, input logic [15:0] val);
      dbg_sel = idx;
      #1;
      chk("reg_literal", dbg_data, val);
   endtask

   initial begin
      int c, e1, e2, e3;
      reset = 1'b1; instr_valid = 1'b0; instr = 16'd0; dbg_sel = 3'd0;
      repeat (3) step();
      reset = 1'b0;
      #1;
      chk("rst_ready", instr_ready, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_div_err", div_err, 1'b0);
      chk("rst_alu_a", alu_a, 16'd0);
      expect_reg(3'd5, 16'd0);

      mvi(3'd1, 16'h0005);
      mvi(3'd2, 16'h0003);
      issue(enc(3'd0, 3'd1, 3'd2));
      step();
      chk("add_sel", alu_sel, 3'b000);
      chk("add_a", alu_a, 16'h0005);
      chk("add_b", alu_b, 16'h0003);
      chk("add_done_early", done, 1'b0);
      wait_done(c);
      chk("add_latency", c + 1, 2);
      expect_reg(3'd1, 16'h0008);

      mvi(3'd3, 16'h00FF);
      mvi(3'd4, 16'h0100);
      run(enc(3'd3, 3'd3, 3'd4));
      expect_reg(3'd3, 16'hFF00);
      mvi(3'd4, 16'h0000);
      run(enc(3'd2, 3'd4, 3'd3));
      expect_reg(3'd4, 16'h0100);

      mvi(3'd5, 16'h0007);
      mvi(3'd6, 16'h0000);
      issue(enc(3'd4, 3'd5, 3'd6));
      wait_done(c);
      chk("div_latency", c, 2);
      chk("div_err_set", div_err, 1'b1);
      expect_reg(3'd5, 16'h0007);
      run(enc(3'd0, 3'd1, 3'd2));
      expect_reg(3'd1, 16'h000B);
      chk("div_err_sticky", div_err, 1'b1);

      mvi(3'd7, 16'hF00F);
      run(enc(3'd5, 3'd0, 3'd7));
      expect_reg(3'd0, 16'h0008);
      issue(enc(3'd7, 3'd1, 3'd7));
      wait_done(c);
      chk("mv_latency", c, 1);
      expect_reg(3'd1, 16'hF00F);

      issue(enc(3'd0, 3'd2, 3'd2)); e1 = edge_n;
      issue(enc(3'd0, 3'd2, 3'd2)); e2 = edge_n;
      issue(enc(3'd0, 3'd2, 3'd2)); e3 = edge_n;
      chk("b2b_gap1", e2 - e1, 3);
      chk("b2b_gap2", e3 - e2, 3);
      wait_done(c);
      expect_reg(3'd2, 16'h0018);

      issue(enc(3'd6, 3'd3, 3'd0));
      repeat (5) step();
      chk("imm_wait_ready", instr_ready, 1'b1);
      chk("imm_wait_done", done, 1'b0);
      issue(16'h1234);
      chk("imm_done", done, 1'b1);
      expect_reg(3'd3, 16'h1234);

      mvi(3'd1, 16'h0005);
      issue(enc(3'd0, 3'd1, 3'd2));
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_exec_done", done, 1'b0);
      #1;
      chk("rst_exec_ready", instr_ready, 1'b1);
      chk("rst_exec_div_err", div_err, 1'b0);
      for (int i = 0; i < 8; i++) expect_reg(3'(i), 16'd0);
      step();
      chk("rst_exec_no_done", done, 1'b0);

      issue(enc(3'd6, 3'd1, 3'd0));
      reset = 1'b1;
      step();
      reset = 1'b0;
      issue(16'hC400);
      issue(16'h0077);
      chk("rst_imm_done", done, 1'b1);
      expect_reg(3'd1, 16'h0077);

      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         instr_valid = ($urandom_range(0, 2) != 0);
         instr = 16'($urandom);
         dbg_sel = 3'($urandom_range(0, 7));
         step();
      end
      reset = 1'b0;
      instr_valid = 1'b0;
      repeat (5) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
